// File: rtl/pong_match_controller.sv
// Match sequencer for Pong: serve countdown, rally, point pause and game over,
// with score keeping and ball reset/enable control. All timing is in frames.
module pong_match_controller #(
  parameter int SCORE_LIMIT  = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int SCORE_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               p1_miss,
  input  logic               p2_miss,
  output logic               ball_reset,
  output logic               ball_enable,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic [2:0]         state_out
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [SCORE_W-1:0] LIMIT      = SCORE_W'(SCORE_LIMIT);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    RUNNING   = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [SCORE_W-1:0] p1_score_r, p1_score_s;
  logic [SCORE_W-1:0] p2_score_r, p2_score_s;
  logic [1:0]         winner_r, winner_s;
  logic               serve_dir_r, serve_dir_s;
  logic               start_d_r;
  logic               ball_reset_r, ball_reset_s;
  logic               ball_enable_r, ball_enable_s;
  logic               start_rise_s;

  assign start_rise_s = start & ~start_d_r;

  // Next-state, counter and score logic
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    p1_score_s  = p1_score_r;
    p2_score_s  = p2_score_r;
    winner_s    = winner_r;
    serve_dir_s = serve_dir_r;
    case (state_r)
      IDLE, GAME_OVER: begin
        if (start_rise_s) begin
          state_s    = SERVE;
          cnt_s      = {CNT_W{1'b0}};
          p1_score_s = {SCORE_W{1'b0}};
          p2_score_s = {SCORE_W{1'b0}};
          winner_s   = 2'b00;
        end else begin
          state_s = state_r;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_r == SERVE_LAST) begin
            state_s = RUNNING;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      RUNNING: begin
        // A double miss is a replay: nobody scores and the serve repeats.
        if (p1_miss && p2_miss) begin
          state_s = SERVE;
        end else if (p2_miss) begin
          if (p1_score_r < LIMIT) begin
            p1_score_s = p1_score_r + SCORE_W'(1);
          end else begin
            p1_score_s = p1_score_r;
          end
          serve_dir_s = 1'b1;
          state_s     = POINT;
        end else if (p1_miss) begin
          if (p2_score_r < LIMIT) begin
            p2_score_s = p2_score_r + SCORE_W'(1);
          end else begin
            p2_score_s = p2_score_r;
          end
          serve_dir_s = 1'b0;
          state_s     = POINT;
        end else begin
          state_s = RUNNING;
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_r == POINT_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            if (p1_score_r == LIMIT) begin
              state_s  = GAME_OVER;
              winner_s = 2'b01;
            end else if (p2_score_r == LIMIT) begin
              state_s  = GAME_OVER;
              winner_s = 2'b10;
            end else begin
              state_s = SERVE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Ball control derived from the upcoming state so it lines up with state_out
  always_comb begin
    ball_reset_s  = 1'b1;
    ball_enable_s = 1'b0;
    case (state_s)
      RUNNING: begin
        ball_reset_s  = 1'b0;
        ball_enable_s = 1'b1;
      end
      POINT: begin
        ball_reset_s  = 1'b0;
        ball_enable_s = 1'b0;
      end
      default: begin
        ball_reset_s  = 1'b1;
        ball_enable_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      p1_score_r    <= {SCORE_W{1'b0}};
      p2_score_r    <= {SCORE_W{1'b0}};
      winner_r      <= 2'b00;
      serve_dir_r   <= 1'b1;
      start_d_r     <= 1'b0;
      ball_reset_r  <= 1'b1;
      ball_enable_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      p1_score_r    <= p1_score_s;
      p2_score_r    <= p2_score_s;
      winner_r      <= winner_s;
      serve_dir_r   <= serve_dir_s;
      start_d_r     <= start;
      ball_reset_r  <= ball_reset_s;
      ball_enable_r <= ball_enable_s;
    end
  end

  assign ball_reset  = ball_reset_r;
  assign ball_enable = ball_enable_r;
  assign serve_dir   = serve_dir_r;
  assign p1_score    = p1_score_r;
  assign p2_score    = p2_score_r;
  assign winner      = winner_r;
  assign state_out   = state_r;

endmodule
